// File: rtl/wb_stage_q.sv
// Write-back retire queue: in-order FIFO that retires results to the register file and raises exception/ertn flushes.
// Optional forwarding query logic is compiled only when WS_FWD_EN is defined.
module wb_stage_q #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ms_to_ws_valid,
    output logic                    ws_allowin,
    input  logic [DATA_W-1:0]       ms_pc,
    input  logic [4:0]              ms_dest,
    input  logic                    ms_gr_we,
    input  logic [DATA_W-1:0]       ms_result,
    input  logic                    ms_excp,
    input  logic [15:0]             ms_excp_num,
    input  logic                    ms_ertn,
    input  logic                    rf_ready,
    output logic                    rf_we,
    output logic [4:0]              rf_waddr,
    output logic [DATA_W-1:0]       rf_wdata,
    output logic                    excp_flush,
    output logic                    ertn_flush,
    output logic [5:0]              ecode,
    output logic [DATA_W-1:0]       epc,
    input  logic [4:0]              fwd_raddr,
    output logic                    fwd_valid,
    output logic [DATA_W-1:0]       fwd_data,
    output logic [$clog2(DEPTH):0]  ws_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] pc_q     [DEPTH];
    logic [4:0]        dest_q   [DEPTH];
    logic              gr_we_q  [DEPTH];
    logic [DATA_W-1:0] result_q [DEPTH];
    logic              excp_q   [DEPTH];
    logic [15:1]       num_q    [DEPTH];
    logic              ertn_q   [DEPTH];

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;

    logic          nonempty;
    logic          pop;
    logic          push;
    logic          flush;
    logic          h_gr_we;
    logic          h_excp;
    logic          h_ertn;
    logic [15:1]   h_num;
    logic          unused_num_bit0;

    // Bit 0 of the exception vector carries no cause code.
    assign unused_num_bit0 = ms_excp_num[0];

    assign nonempty = (count != '0);
    assign h_gr_we  = gr_we_q[head];
    assign h_excp   = excp_q[head];
    assign h_ertn   = ertn_q[head];
    assign h_num    = num_q[head];

    assign pop        = nonempty && (rf_ready || !h_gr_we || h_excp || h_ertn);
    assign excp_flush = pop && h_excp;
    assign ertn_flush = pop && !h_excp && h_ertn;
    assign flush      = excp_flush || ertn_flush;
    assign ws_allowin = !flush && ((count < CW'(DEPTH)) || pop);
    assign push       = ms_to_ws_valid && ws_allowin;

    assign rf_we    = pop && h_gr_we && !h_excp && !h_ertn && (dest_q[head] != 5'd0);
    assign rf_waddr = nonempty ? dest_q[head] : 5'd0;
    assign rf_wdata = nonempty ? result_q[head] : '0;
    assign epc      = nonempty ? pc_q[head] : '0;
    assign ws_count = count;

    always_comb begin
        ecode = 6'h00;
        if (nonempty) begin
            if      (h_num[15]) ecode = 6'h00;
            else if (h_num[14]) ecode = 6'h08;
            else if (h_num[13]) ecode = 6'h3F;
            else if (h_num[12]) ecode = 6'h03;
            else if (h_num[11]) ecode = 6'h07;
            else if (h_num[10]) ecode = 6'h0B;
            else if (h_num[9])  ecode = 6'h0C;
            else if (h_num[8])  ecode = 6'h0D;
            else if (h_num[7])  ecode = 6'h0E;
            else if (h_num[6])  ecode = 6'h09;
            else if (h_num[5])  ecode = 6'h3F;
            else if (h_num[4])  ecode = 6'h04;
            else if (h_num[3])  ecode = 6'h07;
            else if (h_num[2])  ecode = 6'h02;
            else if (h_num[1])  ecode = 6'h01;
        end
    end

    // Payload storage is intentionally unreset; validity comes from count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[tail]     <= ms_pc;
            dest_q[tail]   <= ms_dest;
            gr_we_q[tail]  <= ms_gr_we;
            result_q[tail] <= ms_result;
            excp_q[tail]   <= ms_excp;
            num_q[tail]    <= ms_excp_num[15:1];
            ertn_q[tail]   <= ms_ertn;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= tail;
            count <= '0;
        end else begin
            if (push) tail <= tail + AW'(1);
            if (pop)  head <= head + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef WS_FWD_EN
    logic [AW-1:0] fwd_idx;

    // Walk oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_valid = 1'b0;
        fwd_data  = '0;
        fwd_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head + AW'(i);
            if ((CW'(i) < count) && gr_we_q[fwd_idx] && !excp_q[fwd_idx] &&
                (dest_q[fwd_idx] == fwd_raddr) && (fwd_raddr != 5'd0)) begin
                fwd_valid = 1'b1;
                fwd_data  = result_q[fwd_idx];
            end
        end
    end
`else
    logic unused_fwd_raddr;

    assign unused_fwd_raddr = ^fwd_raddr;
    assign fwd_valid        = 1'b0;
    assign fwd_data         = '0;
`endif

endmodule

// File: tb/tb_wb_stage_q.sv
// Directed self-checking bench for wb_stage_q (DEPTH=4, DATA_W=32).
module tb_wb_stage_q;

    logic        clk = 1'b0;
    logic        reset;
    logic        ms_to_ws_valid;
    logic        ws_allowin;
    logic [31:0] ms_pc;
    logic [4:0]  ms_dest;
    logic        ms_gr_we;
    logic [31:0] ms_result;
    logic        ms_excp;
    logic [15:0] ms_excp_num;
    logic        ms_ertn;
    logic        rf_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        excp_flush;
    logic        ertn_flush;
    logic [5:0]  ecode;
    logic [31:0] epc;
    logic [4:0]  fwd_raddr;
    logic        fwd_valid;
    logic [31:0] fwd_data;
    logic [2:0]  ws_count;

    int checks = 0;
    int errors = 0;

    wb_stage_q #(.DEPTH(4), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
        .ms_pc(ms_pc), .ms_dest(ms_dest), .ms_gr_we(ms_gr_we), .ms_result(ms_result),
        .ms_excp(ms_excp), .ms_excp_num(ms_excp_num), .ms_ertn(ms_ertn),
        .rf_ready(rf_ready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .excp_flush(excp_flush), .ertn_flush(ertn_flush), .ecode(ecode), .epc(epc),
        .fwd_raddr(fwd_raddr), .fwd_valid(fwd_valid), .fwd_data(fwd_data),
        .ws_count(ws_count)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] dest,
                         input logic we, input logic [31:0] res, input logic ex,
                         input logic [15:0] num, input logic er);
        ms_to_ws_valid = v;
        ms_pc          = pc;
        ms_dest        = dest;
        ms_gr_we       = we;
        ms_result      = res;
        ms_excp        = ex;
        ms_excp_num    = num;
        ms_ertn        = er;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        rf_ready = 1'b0;
        fwd_raddr = 5'd0;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 16'h0, 1'b0);
        step;
        step;
        reset = 1'b0;
        #1;
        checks++; if (ws_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", ws_count); end
        checks++; if (ws_allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin got %b want 1", ws_allowin); end
        checks++; if ({rf_we, excp_flush, ertn_flush, fwd_valid} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b want 0000", {rf_we, excp_flush, ertn_flush, fwd_valid}); end
        checks++; if ({rf_waddr, rf_wdata, ecode, epc, fwd_data} !== '0) begin errors++; $display("FAIL reset_data got waddr=%h wdata=%h ecode=%h epc=%h fwd=%h want all 0", rf_waddr, rf_wdata, ecode, epc, fwd_data); end
    endtask

    task automatic test_in_order;
        rf_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) drive(1'b1, 32'h1000 + 32'(k * 4), 5'(k + 1), 1'b1, 32'(8'h11 * (k + 1)), 1'b0, 16'h0, 1'b0);
            else       drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 16'h0, 1'b0);
            #1;
            if (k == 0) begin
                checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL inorder_latency got rf_we=%b want 0", rf_we); end
            end else begin
                checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'(k), 32'(8'h11 * k)}) begin errors++; $display("FAIL inorder_write%0d got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h", k, rf_we, rf_waddr, rf_wdata, k, 8'h11 * k); end
            end
            step;
        end
        checks++; if (ws_count !== 3'd0) begin errors++; $display("FAIL inorder_drained got %0d want 0", ws_count); end
        drive(1'b1, 32'h2000, 5'd0, 1'b1, 32'hDEAD, 1'b0, 16'h0, 1'b0);
        step;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 16'h0, 1'b0);
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL dest0_rf_we got %b want 0", rf_we); end
        step;
        checks++; if (ws_count !== 3'd0) begin errors++; $display("FAIL dest0_popped got %0d want 0", ws_count); end
    endtask

    task automatic test_full;
        rf_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'h3000, 5'(6 + k), 1'b1, 32'(k), 1'b0, 16'h0, 1'b0);
            #1;
            checks++; if (ws_allowin !== (k < 4)) begin errors++; $display("FAIL full_allowin%0d got %b want %b", k, ws_allowin, k < 4); end
            step;
        end
        checks++; if (ws_count !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", ws_count); end
        drive(1'b1, 32'h3000, 5'd10, 1'b1, 32'h55, 1'b0, 16'h0, 1'b0);
        rf_ready = 1'b1;
        #1;
        checks++; if ({ws_allowin, rf_we, rf_waddr} !== {1'b1, 1'b1, 5'd6}) begin errors++; $display("FAIL full_pushpop got allowin=%b we=%b addr=%0d want 1 1 6", ws_allowin, rf_we, rf_waddr); end
        step;
        checks++; if (ws_count !== 3'd4) begin errors++; $display("FAIL full_count_kept got %0d want 4", ws_count); end
        drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 16'h0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if ({rf_we, rf_waddr} !== {1'b1, 5'(7 + k)}) begin errors++; $display("FAIL full_drain%0d got we=%b addr=%0d want 1 %0d", k, rf_we, rf_waddr, 7 + k); end
            step;
        end
        checks++; if (ws_count !== 3'd0) begin errors++; $display("FAIL full_empty got %0d want 0", ws_count); end
    endtask

    task automatic test_excp;
        rf_ready = 1'b0;
        drive(1'b1, 32'h100, 5'd1, 1'b1, 32'hA, 1'b0, 16'h0000, 1'b0); step;
        drive(1'b1, 32'h104, 5'd2, 1'b1, 32'hB, 1'b1, 16'h0040, 1'b0); step;
        drive(1'b1, 32'h108, 5'd3, 1'b1, 32'hC, 1'b0, 16'h0000, 1'b0); step;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 16'h0, 1'b0);
        #1;
        checks++; if ({ws_count, epc, rf_we} !== {3'd3, 32'h100, 1'b0}) begin errors++; $display("FAIL excp_stall got count=%0d epc=%h we=%b want 3 100 0", ws_count, epc, rf_we); end
        rf_ready = 1'b1;
        #1;
        checks++; if ({rf_we, rf_waddr} !== {1'b1, 5'd1}) begin errors++; $display("FAIL excp_a_write got we=%b addr=%0d want 1 1", rf_we, rf_waddr); end
        step;
        checks++; if ({excp_flush, ertn_flush, rf_we, ws_allowin} !== 4'b1000) begin errors++; $display("FAIL excp_b_flags got excp=%b ertn=%b we=%b allowin=%b want 1000", excp_flush, ertn_flush, rf_we, ws_allowin); end
        checks++; if ({ecode, epc} !== {6'h09, 32'h104}) begin errors++; $display("FAIL excp_b_cause got ecode=%h epc=%h want 09 104", ecode, epc); end
        step;
        checks++; if ({ws_count, rf_we, excp_flush} !== {3'd0, 1'b0, 1'b0}) begin errors++; $display("FAIL excp_after got count=%0d we=%b excp=%b want 0 0 0", ws_count, rf_we, excp_flush); end
        step;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL excp_c_written got rf_we=%b want 0", rf_we); end
        drive(1'b1, 32'h110, 5'd4, 1'b0, 32'h0, 1'b1, 16'h2040, 1'b0); step;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 16'h0, 1'b0);
        #1;
        checks++; if ({excp_flush, ecode} !== {1'b1, 6'h3F}) begin errors++; $display("FAIL ecode_tlbr got excp=%b ecode=%h want 1 3f", excp_flush, ecode); end
        step;
        drive(1'b1, 32'h114, 5'd4, 1'b0, 32'h0, 1'b1, 16'h0006, 1'b0); step;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 16'h0, 1'b0);
        #1;
        checks++; if ({excp_flush, ecode} !== {1'b1, 6'h02}) begin errors++; $display("FAIL ecode_pis got excp=%b ecode=%h want 1 02", excp_flush, ecode); end
        step;
        drive(1'b1, 32'h118, 5'd4, 1'b0, 32'h0, 1'b1, 16'h0001, 1'b0); step;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 16'h0, 1'b0);
        #1;
        checks++; if ({excp_flush, ecode} !== {1'b1, 6'h00}) begin errors++; $display("FAIL ecode_none got excp=%b ecode=%h want 1 00", excp_flush, ecode); end
        step;
    endtask

    task automatic test_ertn;
        rf_ready = 1'b0;
        drive(1'b1, 32'h200, 5'd4, 1'b1, 32'h77, 1'b0, 16'h0, 1'b1); step;
        drive(1'b1, 32'h204, 5'd9, 1'b1, 32'h99, 1'b0, 16'h0, 1'b0);
        #1;
        checks++; if ({ertn_flush, excp_flush, ws_allowin, rf_we} !== 4'b1000) begin errors++; $display("FAIL ertn_flags got ertn=%b excp=%b allowin=%b we=%b want 1000", ertn_flush, excp_flush, ws_allowin, rf_we); end
        checks++; if (epc !== 32'h200) begin errors++; $display("FAIL ertn_epc got %h want 200", epc); end
        step;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 16'h0, 1'b0);
        #1;
        checks++; if ({ws_count, rf_we} !== {3'd0, 1'b0}) begin errors++; $display("FAIL ertn_dropped got count=%0d we=%b want 0 0", ws_count, rf_we); end
    endtask

    task automatic test_fwd;
        logic       exp_v;
        logic [31:0] exp_d;
        rf_ready = 1'b0;
        drive(1'b1, 32'h300, 5'd5, 1'b1, 32'hAAAA, 1'b0, 16'h0,    1'b0); step;
        drive(1'b1, 32'h304, 5'd5, 1'b1, 32'hBBBB, 1'b0, 16'h0,    1'b0); step;
        drive(1'b1, 32'h308, 5'd7, 1'b0, 32'hCCCC, 1'b0, 16'h0,    1'b0); step;
        drive(1'b1, 32'h30C, 5'd5, 1'b1, 32'hDDDD, 1'b1, 16'h0040, 1'b0); step;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 16'h0, 1'b0);
`ifdef WS_FWD_EN
        exp_v = 1'b1;
        exp_d = 32'hBBBB;
`else
        exp_v = 1'b0;
        exp_d = 32'h0;
`endif
        fwd_raddr = 5'd5;
        #1;
        checks++; if ({fwd_valid, fwd_data} !== {exp_v, exp_d}) begin errors++; $display("FAIL fwd_youngest got v=%b d=%h want v=%b d=%h", fwd_valid, fwd_data, exp_v, exp_d); end
        fwd_raddr = 5'd0;
        #1;
        checks++; if ({fwd_valid, fwd_data} !== {1'b0, 32'h0}) begin errors++; $display("FAIL fwd_r0 got v=%b d=%h want 0 0", fwd_valid, fwd_data); end
        fwd_raddr = 5'd7;
        #1;
        checks++; if ({fwd_valid, fwd_data} !== {1'b0, 32'h0}) begin errors++; $display("FAIL fwd_no_we got v=%b d=%h want 0 0", fwd_valid, fwd_data); end
        rf_ready = 1'b1;
        step; step; step; step;
        fwd_raddr = 5'd5;
        #1;
        checks++; if ({ws_count, fwd_valid} !== {3'd0, 1'b0}) begin errors++; $display("FAIL fwd_drained got count=%0d v=%b want 0 0", ws_count, fwd_valid); end
        fwd_raddr = 5'd0;
    endtask

    task automatic test_reset_mid;
        rf_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h400 + 32'(k * 4), 5'(11 + k), 1'b1, 32'(k), 1'b0, 16'h0, 1'b0);
            step;
        end
        drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 16'h0, 1'b0);
        #1;
        checks++; if (ws_count !== 3'd3) begin errors++; $display("FAIL rstmid_pre got %0d want 3", ws_count); end
        rf_ready = 1'b1;
        reset = 1'b1;
        step;
        reset = 1'b0;
        #1;
        checks++; if ({ws_count, rf_we, ws_allowin} !== {3'd0, 1'b0, 1'b1}) begin errors++; $display("FAIL rstmid_post got count=%0d we=%b allowin=%b want 0 0 1", ws_count, rf_we, ws_allowin); end
        step;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rstmid_stays got rf_we=%b want 0", rf_we); end
    endtask

    initial begin
        test_reset;
        test_in_order;
        test_full;
        test_excp;
        test_ertn;
        test_fwd;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_stage_q.md
WB_STAGE_Q -- requirements
Module: wb_stage_q

Interface
REQ-001 SHALL have parameter DEPTH, default 4, retire-queue entries (power of two, 2..16).
REQ-002 SHALL have parameter DATA_W, default 32, result and PC width.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports ms_to_ws_valid in 1, ws_allowin out 1: upstream valid/allowin handshake.
REQ-006 SHALL have ports ms_pc in DATA_W, ms_dest in 5, ms_gr_we in 1, ms_result in DATA_W, ms_excp in 1, ms_excp_num in 16, ms_ertn in 1: entry payload.
REQ-007 SHALL have port rf_ready  input  1  register-file write port available this cycle.
REQ-008 SHALL have ports rf_we out 1, rf_waddr out 5, rf_wdata out DATA_W: register-file write.
REQ-009 SHALL have ports excp_flush out 1, ertn_flush out 1, ecode out 6, epc out DATA_W: exception retire.
REQ-010 SHALL have ports fwd_raddr in 5, fwd_valid out 1, fwd_data out DATA_W: forwarding query.
REQ-011 SHALL have port ws_count  output  log2(DEPTH)+1  current occupancy.

Function
REQ-012 SHALL hold entries in an in-order circular FIFO (head/tail pointers wrap modulo DEPTH, separate count).
REQ-013 SHALL push when ms_to_ws_valid && ws_allowin; entry appears at head earliest the next cycle (1-cycle minimum latency).
REQ-014 SHALL pop the head when count>0 and (rf_ready or head gr_we==0 or head excp or head ertn).
REQ-015 SHALL drive rf_we = pop && head gr_we && !head excp && !head ertn, with rf_waddr/rf_wdata from head; rf_we SHALL never assert when dest==0.
REQ-016 SHALL assert excp_flush for exactly the pop cycle of a head with excp=1; ertn_flush likewise for excp=0, ertn=1; excp takes priority.
REQ-017 SHALL, on a flush cycle, empty the queue (count=0, head=tail) at the clock edge and discard any push offered that cycle.
REQ-018 SHALL drive ws_allowin = !flush && (count<DEPTH || pop); push and pop in the same cycle at full SHALL be accepted, count unchanged.
REQ-019 SHALL drive ecode by priority on head excp_num bit15..1: INT 0x00, ADE 0x08, TLBR 0x3F, PIF 0x03, PPI 0x07, SYS 0x0B, BRK 0x0C, INE 0x0D, IPE 0x0E, ALE 0x09, TLBR 0x3F, PME 0x04, PPI 0x07, PIS 0x02, PIL 0x01; otherwise 0x00.
REQ-020 SHALL drive epc = head pc whenever count>0, else 0.
REQ-021 SHALL drive fwd_valid=1, fwd_data=result of the youngest queued entry with gr_we=1, excp=0, dest==fwd_raddr, fwd_raddr!=0; else fwd_valid=0, fwd_data=0.
REQ-022 SHALL be purely combinational for fwd_*, rf_*, *_flush, ecode, epc (no added cycle).

Reset
REQ-023 SHALL, when reset=1 at a clock edge, set count=0, head=tail=0, overriding any push, pop or flush that cycle.
REQ-024 SHALL hold all outputs 0 while empty after reset, with ws_allowin=1.
REQ-025 SHALL leave entry payload storage unreset (only valid tracking reset).

Configuration
REQ-026 SHALL compile the forwarding query port logic only when WS_FWD_EN is defined.
REQ-027 SHALL, without WS_FWD_EN, keep fwd_* ports present with fwd_valid=0 and fwd_data=0 constantly.

Verification
REQ-028 Push 4 entries (dest 1..4, result 0x11..0x44, gr_we=1), rf_ready=1 -> rf_we on 4 consecutive cycles, waddr 1,2,3,4 in order.
REQ-029 DEPTH=4, rf_ready=0, push 5 -> ws_allowin=0 after 4, ws_count=4; rf_ready=1 with push -> pop+push same cycle, count stays 4.
REQ-030 Queue entries A(gr_we) , B(excp_num bit6), C; head B pops -> excp_flush=1 one cycle, ecode=0x09, epc=B pc, no rf_we for B, count=0 next cycle, C never written.
REQ-031 Two entries dest 5 results 0xAAAA then 0xBBBB, fwd_raddr=5 -> fwd_data=0xBBBB (WS_FWD_EN defined); fwd_raddr=0 -> fwd_valid=0; macro undefined -> fwd_valid=0.
REQ-032 Head ertn=1 -> ertn_flush=1, excp_flush=0; push offered same cycle dropped (ws_allowin=0).
REQ-033 Assert reset with 3 entries and rf_ready=1 -> next cycle count=0, rf_we=0, ws_allowin=1.
